snoop_bus_arbiter: RTL

- Round-robin arbiter and sequencer for the shared snooping bus between the per-core L1 caches and unified memory in the multicore processor.
- Grants one core's bus_op_t transaction (READ_MISS_0/1, WRITE_MISS_0/1, INVALIDATE) at a time and broadcasts it to all snoopers.
- Sequences the optional write-back from a remote MODIFIED holder, then the memory fill.
- Signals completion to the requester.

---
 rtl/snoop_bus_arbiter_pkg.sv | 26 ++
 rtl/snoop_bus_arbiter_rr.sv | 29 ++
 rtl/snoop_bus_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared snooping-bus types: bus operations, arbiter FSM states and op predicates.
package snoop_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    NOOP         = 3'd0,
    READ_MISS_0  = 3'd1,
    READ_MISS_1  = 3'd2,
    WRITE_MISS_0 = 3'd3,
    WRITE_MISS_1 = 3'd4,
    INVALIDATE   = 3'd5
  } bus_op_t;

  typedef enum logic [2:0] {
    SB_IDLE,
    SB_GRANT,
    SB_WB,
    SB_FILL,
    SB_DONE
  } snoop_bus_state_t;

  function automatic logic is_miss_op(bus_op_t op);
    return (op == READ_MISS_0) || (op == READ_MISS_1) ||
           (op == WRITE_MISS_0) || (op == WRITE_MISS_1);
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] k;
    k     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter/sequencer: grant, broadcast, optional write-back, fill, done.
// Optional memory watchdog enabled by defining SNOOP_BUS_WDOG_EN.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 16,
  parameter int WDOG_CYC  = 64,
  parameter int IW        = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*3-1:0]      req_op,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES-1:0]        snoop_mod,
  input  logic                        mem_rdy,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        done,
  output logic                        bus_valid,
  output logic [2:0]                  bus_op,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [IW-1:0]               bus_owner,
  output logic                        mem_req,
  output logic                        mem_we,
`ifdef SNOOP_BUS_WDOG_EN
  output logic                        bus_err,
`endif
  output logic [IW-1:0]               wb_src
);

  snoop_bus_state_t  state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, wb_src_q, wb_src_d;
  bus_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [NUM_CORES-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx, rem_idx;
  logic                 arb_any, rem_any;

`ifdef SNOOP_BUS_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, wdog_hit;
  assign wdog_hit = !mem_rdy && (cnt_q == CW'(WDOG_CYC - 1));
`endif

  rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Lowest remote MODIFIED holder; the owner's own copy never needs a write-back.
  always_comb begin
    rem_any = 1'b0;
    rem_idx = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (snoop_mod[j] && (IW'(j) != owner_q)) begin
        rem_any = 1'b1;
        rem_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      wb_src_q <= '0;
      op_q     <= NOOP;
      addr_q   <= '0;
`ifdef SNOOP_BUS_WDOG_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wb_src_q <= wb_src_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
`ifdef SNOOP_BUS_WDOG_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wb_src_d = wb_src_q;
    op_d     = op_q;
    addr_d   = addr_q;
`ifdef SNOOP_BUS_WDOG_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      SB_IDLE: if (arb_any) begin
        owner_d  = arb_idx;
        op_d     = bus_op_t'(req_op[arb_idx*3 +: 3]);
        addr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
        rr_ptr_d = (arb_idx == IW'(NUM_CORES - 1)) ? '0 : arb_idx + IW'(1);
        state_d  = SB_GRANT;
      end
      SB_GRANT: begin
        if (!is_miss_op(op_q)) state_d = SB_DONE;
        else if (rem_any) begin
          wb_src_d = rem_idx;
          state_d  = SB_WB;
        end else state_d = SB_FILL;
      end
      SB_WB: begin
        if (mem_rdy) state_d = SB_FILL;
`ifdef SNOOP_BUS_WDOG_EN
        else if (wdog_hit) begin
          state_d = SB_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      SB_FILL: begin
        if (mem_rdy) state_d = SB_DONE;
`ifdef SNOOP_BUS_WDOG_EN
        else if (wdog_hit) begin
          state_d = SB_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      SB_DONE: state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
`ifdef SNOOP_BUS_WDOG_EN
    // Counter restarts on every state change, so WB and FILL each get a full window.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
`endif
  end

  always_comb begin
    gnt       = '0;
    done      = '0;
    bus_valid = 1'b0;
    bus_op    = NOOP;
    bus_addr  = '0;
    bus_owner = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    wb_src    = '0;
    if (state_q != SB_IDLE) begin
      gnt[owner_q] = 1'b1;
      bus_addr     = addr_q;
      bus_owner    = owner_q;
    end
    if (state_q == SB_GRANT && op_q != NOOP) begin
      bus_valid = 1'b1;
      bus_op    = op_q;
    end
    if (state_q == SB_WB) begin
      mem_req = 1'b1;
      mem_we  = 1'b1;
      wb_src  = wb_src_q;
    end
    if (state_q == SB_FILL) mem_req = 1'b1;
    if (state_q == SB_DONE) done[owner_q] = 1'b1;
  end

`ifdef SNOOP_BUS_WDOG_EN
  assign bus_err = err_q;
`endif

endmodule
